// File: rtl/fpu_mul_result_queue.sv
// Result queue behind fpu_32_multiplier.
// Accepts product words and their overflow/underflow flags over a valid/ready
// handshake. Each word is tagged as NaN or not, and held in a DEPTH-entry
// first-word-fall-through FIFO until the writeback consumer takes it.
// The block also keeps sticky exception flags that software can clear, and a
// saturating count of accepted operations.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready producer handshake (in_ready = not full)
//   in_res/in_of/in_uf product word and its multiplier flags
//   out_valid/out_ready consumer handshake (out_valid = not empty)
//   out_res/out_of/out_uf/out_nan  head entry; hold last popped entry when empty
//   flag_clr          clears sticky flags (a same-cycle flagged push wins)
//   sticky_of/uf/nan  OR of flags over accepted pushes since last clear
//   op_count          accepted pushes, saturating at all-ones
//   level             occupancy, 0..DEPTH
module fpu_mul_result_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_res,
  input  logic                       in_of,
  input  logic                       in_uf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_res,
  output logic                       out_of,
  output logic                       out_uf,
  output logic                       out_nan,
  input  logic                       flag_clr,
  output logic                       sticky_of,
  output logic                       sticky_uf,
  output logic                       sticky_nan,
  output logic [CNT_W-1:0]           op_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] res;
    logic        of;
    logic        uf;
    logic        nan;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             in_entry;
  entry_t             head;
  entry_t             last_q, last_d;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sticky_of_q, sticky_of_d;
  logic               sticky_uf_q, sticky_uf_d;
  logic               sticky_nan_q, sticky_nan_d;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               in_is_nan;

  // Handshake qualifiers; in_ready depends only on registered occupancy.
  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == LVL_W'(0));
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = ~empty & out_ready;

  // NaN: all-ones exponent with non-zero mantissa; infinity is not NaN.
  assign in_is_nan = (in_res[30:23] == 8'hFF) && (in_res[22:0] != 23'd0);

  always_comb begin
    in_entry     = '0;
    in_entry.res = in_res;
    in_entry.of  = in_of;
    in_entry.uf  = in_uf;
    in_entry.nan = in_is_nan;
  end

  // Storage array; contents are only ever read behind a valid occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // Head is fall-through from storage; when empty, show the last popped entry.
  always_comb begin
    head = last_q;
    if (!empty) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign out_res = head.res;
  assign out_of  = head.of;
  assign out_uf  = head.uf;
  assign out_nan = head.nan;

  // Next-state for pointers, occupancy, hold register, flags and counter.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    last_d       = last_q;
    count_d      = count_q;
    sticky_of_d  = sticky_of_q;
    sticky_uf_d  = sticky_uf_q;
    sticky_nan_d = sticky_nan_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      last_d   = mem_q[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (push && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end

    // Clear first, then a flagged push in the same cycle sets the flag again.
    if (flag_clr) begin
      sticky_of_d  = 1'b0;
      sticky_uf_d  = 1'b0;
      sticky_nan_d = 1'b0;
    end
    if (push) begin
      sticky_of_d  = sticky_of_d  | in_of;
      sticky_uf_d  = sticky_uf_d  | in_uf;
      sticky_nan_d = sticky_nan_d | in_is_nan;
    end
  end

  // Control state; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      last_q       <= '0;
      count_q      <= '0;
      sticky_of_q  <= 1'b0;
      sticky_uf_q  <= 1'b0;
      sticky_nan_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      last_q       <= last_d;
      count_q      <= count_d;
      sticky_of_q  <= sticky_of_d;
      sticky_uf_q  <= sticky_uf_d;
      sticky_nan_q <= sticky_nan_d;
    end
  end

  assign sticky_of  = sticky_of_q;
  assign sticky_uf  = sticky_uf_q;
  assign sticky_nan = sticky_nan_q;
  assign op_count   = count_q;
  assign level      = level_q;

endmodule

// File: tb/tb_fpu_mul_result_queue.sv
module tb_fpu_mul_result_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_res;
  logic              in_of;
  logic              in_uf;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_res;
  logic              out_of;
  logic              out_uf;
  logic              out_nan;
  logic              flag_clr;
  logic              sticky_of;
  logic              sticky_uf;
  logic              sticky_nan;
  logic [CNT_W-1:0]  op_count;
  logic [LVL_W-1:0]  level;

  fpu_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_of(in_of), .in_uf(in_uf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_of(out_of), .out_uf(out_uf), .out_nan(out_nan),
    .flag_clr(flag_clr),
    .sticky_of(sticky_of), .sticky_uf(sticky_uf), .sticky_nan(sticky_nan),
    .op_count(op_count), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of {res, of, uf} words.
  logic [33:0] mq [$];
  logic [33:0] m_last;
  bit          m_sof, m_suf, m_snan;
  int          m_cnt;

  function automatic bit is_nan(input logic [31:0] w);
    int e, m;
    e = int'(w >> 23) % 256;
    m = int'(w) & 32'h007F_FFFF;
    return (e == 255) && (m != 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_sof = 0; m_suf = 0; m_snan = 0;
    m_cnt = 0;
  endtask

  // One clock with the given inputs; model advances from the pre-edge state.
  task automatic cyc(input bit v, input logic [31:0] r, input bit of_, input bit uf_,
                     input bit ordy, input bit clr);
    bit do_push, do_pop;
    in_valid = v; out_ready = ordy; flag_clr = clr;
    if (v) begin
      in_res = r; in_of = of_; in_uf = uf_;
    end else begin
      in_res = 'x; in_of = 'x; in_uf = 'x;
    end
    @(posedge clk);
    do_push = v && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() > 0);
    if (clr) begin
      m_sof = 0; m_suf = 0; m_snan = 0;
    end
    if (do_pop) m_last = mq.pop_front();
    if (do_push) begin
      mq.push_back({r, of_, uf_});
      if (of_) m_sof = 1;
      if (uf_) m_suf = 1;
      if (is_nan(r)) m_snan = 1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    in_res = 'x; in_of = 'x; in_uf = 'x;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [33:0] h;
    if (rst_n) begin
      h = (mq.size() > 0) ? mq[0] : m_last;
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
      check("level",     64'(level),     64'(mq.size()));
      check("op_count",  64'(op_count),  64'(m_cnt));
      check("sticky_of", 64'(sticky_of), 64'(m_sof));
      check("sticky_uf", 64'(sticky_uf), 64'(m_suf));
      check("sticky_nan",64'(sticky_nan),64'(m_snan));
      check("out_res",   64'(out_res),   64'(h[33:2]));
      check("out_of",    64'(out_of),    64'(h[1]));
      check("out_uf",    64'(out_uf),    64'(h[0]));
      check("out_nan",   64'(out_nan),   64'(is_nan(h[33:2])));
    end
  end

  logic [31:0] a_vec [5];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    in_res = 'x; in_of = 'x; in_uf = 'x;
    model_reset();
    #2;
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_res", 64'(out_res), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single push, one cycle to visibility
    cyc(1, 32'hC67A0800, 0, 0, 0, 0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_res", 64'(out_res), 64'hC67A0800);
    check("t1_level", 64'(level), 64'd1);
    check("t1_cnt", 64'(op_count), 64'd1);
    check("t1_sticky", 64'({sticky_of, sticky_uf, sticky_nan}), 64'd0);
    cyc(0, 0, 0, 0, 1, 0);
    check("t1_empty_hold", 64'(out_res), 64'hC67A0800);

    // 2: fill beyond DEPTH, then drain in order
    a_vec[0] = 32'h3F800000; a_vec[1] = 32'h40000000; a_vec[2] = 32'hC0400000;
    a_vec[3] = 32'h00800000; a_vec[4] = 32'h7F7FFFFF;
    for (int i = 0; i < 5; i++) cyc(1, a_vec[i], i[0], i[1], 0, 0);
    check("t2_in_ready", 64'(in_ready), 64'd0);
    check("t2_level", 64'(level), 64'd4);
    // Full queue rejects a push even while popping.
    cyc(1, 32'h12345678, 0, 0, 1, 0);
    check("t2_full_pop_level", 64'(level), 64'd3);
    for (int i = 1; i < 4; i++) begin
      check("t2_drain", 64'(out_res), 64'(a_vec[i]));
      cyc(0, 0, 0, 0, 1, 0);
    end
    check("t2_drained", 64'(out_valid), 64'd0);

    // 3: steady stream at level 1 across pointer wrap; saturates op_count too
    cyc(1, 32'h41000000, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 32'h41000000 + 32'(i + 1), 0, 0, 1, 0);
    check("t3_level", 64'(level), 64'd1);
    check("t3_res", 64'(out_res), 64'h41000014);
    check("t3_cnt_sat", 64'(op_count), 64'd15);
    cyc(0, 0, 0, 0, 1, 0);

    // 4: NaN tagging, infinity, sticky clear
    cyc(1, 32'h7FC00000, 0, 0, 0, 0);
    check("t4_nan", 64'(out_nan), 64'd1);
    check("t4_snan", 64'(sticky_nan), 64'd1);
    cyc(1, 32'h7F800000, 1, 0, 1, 0);
    check("t4_inf_not_nan", 64'(out_nan), 64'd0);
    check("t4_sof", 64'(sticky_of), 64'd1);
    cyc(0, 0, 0, 0, 1, 1);
    check("t4_clr", 64'({sticky_of, sticky_uf, sticky_nan}), 64'd0);

    // 5: set beats clear in the same cycle
    cyc(1, 32'h00000001, 0, 1, 0, 1);
    check("t5_suf", 64'(sticky_uf), 64'd1);
    cyc(0, 0, 0, 0, 1, 0);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) cyc(1, 32'hA0000000 + 32'(i), 0, 0, 0, 0);
    check("t6_level3", 64'(level), 64'd3);
    in_valid = 1'b1; in_res = 32'hBEEF0000; in_of = 1'b0; in_uf = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_level", 64'(level), 64'd0);
    check("t6_async_valid", 64'(out_valid), 64'd0);
    check("t6_async_cnt", 64'(op_count), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 32'h00000000, 0, 0, 0, 0);
    check("t6_sole_valid", 64'(out_valid), 64'd1);
    check("t6_sole_level", 64'(level), 64'd1);
    cyc(0, 0, 0, 0, 1, 0);
    check("t6_after_pop", 64'(out_valid), 64'd0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
